divider: RTL



---
 rtl/divider_pkg.sv | 15 +
 rtl/divider.sv | 127 ++++++++++++
 2 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared constants for the sequential signed divider.
//   WORD   - datapath width
//   CNT_W  - iteration counter width (counts 0..32)
//   ST_*   - FSM state encodings
package divider_pkg;

  localparam int WORD  = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/divider.sv
// divider: sequential signed 32-bit restoring divider for the multicycle
// MIPS datapath. Magnitudes are divided in 32 iterations, then signs are
// applied: quotient truncates toward zero, remainder follows the dividend.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   DivCtrl  in   start request, honoured only in IDLE
//   A        in   dividend (two's complement)
//   B        in   divisor (two's complement)
//   HI       out  remainder, registered, holds between operations
//   LO       out  quotient, registered, holds between operations
//   DivDone  out  one-cycle completion pulse
//   Div0     out  one-cycle divide-by-zero pulse (no operation started)
module divider
  import divider_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            DivCtrl,
  input  logic [WORD-1:0] A,
  input  logic [WORD-1:0] B,
  output logic [WORD-1:0] HI,
  output logic [WORD-1:0] LO,
  output logic            DivDone,
  output logic            Div0
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WORD-1:0]  rem;
  logic [WORD-1:0]  quo;
  logic [WORD-1:0]  b_mag;
  logic             sign_q;
  logic             sign_r;

  // Operand magnitudes at the start edge. As unsigned 32-bit values,
  // |0x80000000| = 0x80000000 is exact.
  logic [WORD-1:0]  a_abs;
  logic [WORD-1:0]  b_abs;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  logic [WORD-1:0]  rem_sh;
  logic [WORD-1:0]  quo_sh;
  logic [WORD:0]    trial;

  // NOTE: every always_comb output gets an unconditional assignment, so no
  // path leaves a value unassigned and no latch can be inferred.
  always_comb begin
    a_abs  = A[WORD-1] ? -A : A;
    b_abs  = B[WORD-1] ? -B : B;
    rem_sh = {rem[WORD-2:0], quo[WORD-1]};
    quo_sh = {quo[WORD-2:0], 1'b0};
    trial  = {1'b0, rem_sh} - {1'b0, b_mag};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      b_mag   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      DivDone <= 1'b0;
      Div0    <= 1'b0;
    end else begin
      // Both flags are single-cycle pulses unless re-raised below.
      DivDone <= 1'b0;
      Div0    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (DivCtrl) begin
            if (B == '0) begin
              Div0 <= 1'b1;
            end else begin
              quo    <= a_abs;
              b_mag  <= b_abs;
              rem    <= '0;
              cnt    <= '0;
              sign_q <= A[WORD-1] ^ B[WORD-1];
              sign_r <= A[WORD-1];
              state  <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          // trial[WORD] is the borrow: clear means the trial remainder >= 0.
          if (!trial[WORD]) begin
            rem <= trial[WORD-1:0];
            quo <= {quo_sh[WORD-1:1], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= quo_sh;
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WORD - 1)) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          LO      <= sign_q ? -quo : quo;
          HI      <= sign_r ? -rem : rem;
          DivDone <= 1'b1;
          state   <= ST_DONE;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
